// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
//
// Front-end controller for the calculator's four-function ALU. Converts the
// synchronised pushbutton levels into hex operand entry, operator selection
// and execution, and latches the result that is shown on the display.
//
// Optional feature macro: CALC_CHAIN_EN
//   defined   : an operator press in SHOW reuses the shown result (truncated
//               to DATA_W bits) as operand A and continues with operand B.
//   undefined : an operator press in SHOW is ignored.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   key_digit    level per hex key 0..F
//   key_op       level per operator key: [0]=ADD [1]=SUB [2]=MUL [3]=DIV
//   key_equal    level of the equals key
//   key_clear    level of the clear key
//   alu_val_a    operand A to the ALU
//   alu_val_b    operand B to the ALU
//   alu_opcode   ALU opcode (0 = idle)
//   alu_result   ALU result (2*DATA_W bits)
//   display      value for the 7-segment display
//   busy         high while waiting for the ALU (EXEC)
//   err          high in the ERROR state
//   state_dbg    current state encoding
// -----------------------------------------------------------------------------
module calc_sequencer #(
  parameter int DATA_W      = 16,
  parameter int MAX_DIGITS  = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         key_digit,
  input  logic [3:0]          key_op,
  input  logic                key_equal,
  input  logic                key_clear,
  output logic [DATA_W-1:0]   alu_val_a,
  output logic [DATA_W-1:0]   alu_val_b,
  output logic [3:0]          alu_opcode,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic [2*DATA_W-1:0] display,
  output logic                busy,
  output logic                err,
  output logic [2:0]          state_dbg
);

  localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int WAIT_W = (EXEC_CYCLES < 2) ? 1 : $clog2(EXEC_CYCLES + 1);
  localparam int KEY_W  = 22;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_EXEC    = 3'd2,
    ST_SHOW    = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  state_t              state_reg,  state_next;
  logic [DATA_W-1:0]   a_reg,      a_next;
  logic [DATA_W-1:0]   b_reg,      b_next;
  logic [3:0]          opcode_reg, opcode_next;
  logic [2*DATA_W-1:0] result_reg, result_next;
  logic [CNT_W-1:0]    count_reg,  count_next;
  logic [WAIT_W-1:0]   wait_reg,   wait_next;

  // Key history: one sampling stage, then the previous-sample stage used for
  // rising-edge detection. A press is therefore acted on one edge after the
  // key is first sampled high.
  logic [KEY_W-1:0] keys_in;
  logic [KEY_W-1:0] keys_smp_reg;
  logic [KEY_W-1:0] keys_prev_reg;
  logic [KEY_W-1:0] press;

  assign keys_in = {key_clear, key_equal, key_op, key_digit};

  genvar gi;
  generate
    for (gi = 0; gi < KEY_W; gi++) begin : g_edge
      assign press[gi] = keys_smp_reg[gi] & ~keys_prev_reg[gi];
    end
  endgenerate

  logic        clr_press;
  logic        eq_press;
  logic [3:0]  op_press;
  logic [15:0] dig_press;

  assign clr_press = press[21];
  assign eq_press  = press[20];
  assign op_press  = press[19:16];
  assign dig_press = press[15:0];

  // Lowest-index digit and operator win when several are pressed together.
  logic       dig_any;
  logic [3:0] dig_val;
  logic       op_any;
  logic [3:0] op_code;

  always_comb begin
    dig_any = 1'b0;
    dig_val = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (dig_press[i]) begin
        dig_any = 1'b1;
        dig_val = 4'(i);
      end
    end
  end

  always_comb begin
    op_any  = 1'b0;
    op_code = OP_NONE;
    for (int i = 3; i >= 0; i--) begin
      if (op_press[i]) begin
        op_any = 1'b1;
        case (i)
          0:       op_code = OP_ADD;
          1:       op_code = OP_SUB;
          2:       op_code = OP_MUL;
          default: op_code = OP_DIV;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_smp_reg  <= '0;
      keys_prev_reg <= '0;
      state_reg     <= ST_ENTER_A;
      a_reg         <= '0;
      b_reg         <= '0;
      opcode_reg    <= OP_NONE;
      result_reg    <= '0;
      count_reg     <= '0;
      wait_reg      <= '0;
    end else begin
      keys_smp_reg  <= keys_in;
      keys_prev_reg <= keys_smp_reg;
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      opcode_reg    <= opcode_next;
      result_reg    <= result_next;
      count_reg     <= count_next;
      wait_reg      <= wait_next;
    end
  end

  // Press priority: clear > equal > op > digit. Only the winning press is
  // acted on; the others in the same cycle are dropped.
  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    opcode_next = opcode_reg;
    result_next = result_reg;
    count_next  = count_reg;
    wait_next   = wait_reg;

    if (clr_press) begin
      state_next  = ST_ENTER_A;
      a_next      = '0;
      b_next      = '0;
      opcode_next = OP_NONE;
      result_next = '0;
      count_next  = '0;
      wait_next   = '0;
    end else begin
      case (state_reg)
        ST_ENTER_A: begin
          if (eq_press) begin
            state_next = ST_ENTER_A;
          end else if (op_any) begin
            opcode_next = op_code;
            count_next  = '0;
            b_next      = '0;
            state_next  = ST_ENTER_B;
          end else if (dig_any && (count_reg < CNT_W'(MAX_DIGITS))) begin
            a_next     = {a_reg[DATA_W-5:0], dig_val};
            count_next = count_reg + CNT_W'(1);
          end
        end

        ST_ENTER_B: begin
          if (eq_press) begin
            if (count_reg != '0) begin
              if ((opcode_reg == OP_DIV) && (b_reg == '0)) begin
                state_next = ST_ERROR;
              end else begin
                wait_next  = WAIT_W'(EXEC_CYCLES);
                state_next = ST_EXEC;
              end
            end
          end else if (op_any) begin
            // The operator may be changed only before any B digit is typed.
            if (count_reg == '0) begin
              opcode_next = op_code;
            end
          end else if (dig_any && (count_reg < CNT_W'(MAX_DIGITS))) begin
            b_next     = {b_reg[DATA_W-5:0], dig_val};
            count_next = count_reg + CNT_W'(1);
          end
        end

        ST_EXEC: begin
          if (wait_reg == WAIT_W'(1)) begin
            result_next = alu_result;
            opcode_next = OP_NONE;
            state_next  = ST_SHOW;
          end else begin
            wait_next = wait_reg - WAIT_W'(1);
          end
        end

        ST_SHOW: begin
          if (eq_press) begin
            state_next = ST_SHOW;
          end else if (op_any) begin
`ifdef CALC_CHAIN_EN
            a_next      = result_reg[DATA_W-1:0];
            b_next      = '0;
            count_next  = '0;
            opcode_next = op_code;
            state_next  = ST_ENTER_B;
`else
            state_next  = ST_SHOW;
`endif
          end else if (dig_any) begin
            a_next      = {{(DATA_W-4){1'b0}}, dig_val};
            b_next      = '0;
            count_next  = CNT_W'(1);
            opcode_next = OP_NONE;
            state_next  = ST_ENTER_A;
          end
        end

        ST_ERROR: begin
          state_next = ST_ERROR;
        end

        default: begin
          state_next = ST_ENTER_A;
        end
      endcase
    end
  end

  // Display source follows the state; during EXEC the B operand that was
  // on screen when equals was pressed stays visible until capture.
  always_comb begin
    display = '0;
    case (state_reg)
      ST_ENTER_A: display = {{DATA_W{1'b0}}, a_reg};
      ST_ENTER_B: display = (count_reg == '0) ? {{DATA_W{1'b0}}, a_reg}
                                              : {{DATA_W{1'b0}}, b_reg};
      ST_EXEC:    display = {{DATA_W{1'b0}}, b_reg};
      ST_SHOW:    display = result_reg;
      ST_ERROR:   display = {(DATA_W/2){4'hE}};
      default:    display = '0;
    endcase
  end

  assign alu_val_a  = a_reg;
  assign alu_val_b  = b_reg;
  assign alu_opcode = opcode_reg;
  assign busy       = (state_reg == ST_EXEC);
  assign err        = (state_reg == ST_ERROR);
  assign state_dbg  = state_reg;

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Front-end controller for the calculator's four-function ALU (ADD=4'b0001, SUB=4'b0010, DIV=4'b0011, MUL=4'b0100; combinational; 16-bit operands in, 32-bit result out).
- Turns pushbutton levels into hex operand entry, operator selection and execution, then latches the displayed result.
- Sits between the button synchronisers and the ALU, and is the only driver of the ALU's operand and opcode inputs.

Parameters:
- DATA_W, 16: operand width; the result is 2*DATA_W.
- MAX_DIGITS, 4: hex digits accepted per operand (MAX_DIGITS*4 == DATA_W).
- EXEC_CYCLES, 1: wait cycles in EXEC before the ALU result is captured; must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- key_digit  in  16  synchronised level per hex key 0..F
- key_op  in  4  synchronised level: [0]=ADD [1]=SUB [2]=MUL [3]=DIV
- key_equal  in  1  synchronised level, equals key
- key_clear  in  1  synchronised level, clear key
- alu_val_a  out  DATA_W  operand A to ALU
- alu_val_b  out  DATA_W  operand B to ALU
- alu_opcode  out  4  ALU opcode; 0 = idle (ALU outputs 0)
- alu_result  in  2*DATA_W  ALU result
- display  out  2*DATA_W  value shown on the 7-segment display
- busy  out  1  high in EXEC
- err  out  1  high in ERROR
- state_dbg  out  3  current state encoding

Behaviour:
- Reset: clk and rst_n form the clock and reset pair; rst_n is asynchronous and active-low. While reset is asserted:
  - all key history flops = 0;
  - state = ENTER_A;
  - alu_val_a, alu_val_b, alu_opcode, display, digit count = 0;
  - busy = 0, err = 0.
- Edge detect: each key is registered once. press = level & ~prev. A key held high produces exactly one press.
- Priority when several presses occur in one cycle: clear > equal > op > digit.
  - Among digits, the lowest index wins.
  - Among ops, the lowest index wins.
- Clear press in any state:
  - next cycle: ENTER_A, operands/opcode/display/count = 0, err = 0;
  - this aborts EXEC (no capture).
- States: ENTER_A=0, ENTER_B=1, EXEC=2, SHOW=3, ERROR=4.
- Digit press, in ENTER_A or ENTER_B:
  - if count < MAX_DIGITS: operand <= {operand[DATA_W-5:0], digit}, count += 1;
  - else ignored; the operand is unchanged, with no wrap.
- ENTER_A:
  - display = {0, alu_val_a};
  - op press -> alu_opcode = op encoding, count = 0, go ENTER_B;
  - equal press is ignored.
- ENTER_B:
  - display = alu_val_a until the first B digit, then {0, alu_val_b};
  - op press with count = 0 replaces alu_opcode; op press with count > 0 is ignored;
  - equal press with count = 0 is ignored;
  - equal press with opcode DIV and B = 0 -> ERROR;
  - otherwise -> EXEC, with the wait counter loaded to EXEC_CYCLES.
- EXEC:
  - busy = 1; operands and opcode are held stable;
  - the counter decrements each cycle; all keys except clear are ignored;
  - when the counter reaches 1: display <= alu_result, go SHOW.
  - Timing: equal press sampled at edge N, so EXEC is entered at N+1 and display updates at edge N+1+EXEC_CYCLES.
- SHOW:
  - display holds the captured result; alu_opcode = 0;
  - digit press -> clear operands, take the digit as the first A digit (count = 1), go ENTER_A;
  - op press: see the optional feature below;
  - equal press is ignored.
- ERROR:
  - err = 1, display = 32'hEEEE_EEEE;
  - only clear exits.
- Arithmetic: SUB underflow is passed through as produced by the ALU (32-bit wrapped value); there is no saturation.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined: an op press in SHOW loads alu_val_a <= display[DATA_W-1:0], alu_val_b <= 0, count = 0, alu_opcode = op, and goes to ENTER_B. Results wider than DATA_W are truncated.
- Undefined: an op press in SHOW is ignored; only a digit or clear leaves SHOW.

Test Plan:
- Reset mid-EXEC (EXEC_CYCLES=4, rst_n low on the 2nd EXEC cycle) -> all outputs 0 and state ENTER_A immediately (asynchronous), with no capture after release.
- Enter A=0x0012 ("1","2"), ADD, B=0x0034, equal -> busy for EXEC_CYCLES, then display=32'h0000_0046, state SHOW, busy=0.
- Enter A=0xFFFF, MUL, B=0xFFFF, equal -> display=32'hFFFE_0001. Separately: 5 digits "1,2,3,4,5" -> alu_val_a=0x1234 (5th ignored).
- Enter A=0x0010, DIV, B=0x0000, equal -> ERROR, err=1, display=32'hEEEE_EEEE. Digit/equal presses then cause no change; clear -> ENTER_A, err=0, display=0.
- Digit 3 and digit 7 pressed in the same cycle -> A=0x0003. Clear and equal in the same cycle -> clear wins. Holding a digit key for 10 cycles -> one digit entered.
- With CALC_CHAIN_EN: 0x0006 MUL 0x0007 = 0x2A, then SUB, 0x0002, equal -> display=32'h0000_0028. Without the macro, SUB in SHOW leaves display=0x2A and state SHOW.
